// File: rtl/alu_operand_stage_if.sv
// Handshake and data bundle around the ALU operand/issue stage.
// The "master" modport is the side that sends issue requests and write-backs and receives operands.
// The "slave" modport is the operand stage itself.
interface alu_operand_stage_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int IMMW = 16
);
  // Issue request side
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [AW-1:0]   in_rs;
  logic [AW-1:0]   in_rt;
  logic [AW-1:0]   in_rd;
  logic [IMMW-1:0] in_imm;
  logic            in_use_imm;

  // Operand side toward the ALU
  logic            alu_valid;
  logic            alu_ready;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [2:0]      alu_op;
  logic [AW-1:0]   alu_rd;

  // Result write-back
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_use_imm,
    input  in_ready,
    input  alu_valid, alu_a, alu_b, alu_op, alu_rd,
    output alu_ready,
    output wb_en, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_use_imm,
    output in_ready,
    output alu_valid, alu_a, alu_b, alu_op, alu_rd,
    input  alu_ready,
    input  wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the ALU: register file, operand read with write-back bypass,
// per-register pending scoreboard, and a registered {a, b, op, rd} output slot.
module alu_operand_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int IMMW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stage_if.slave  bus,
  output logic                err_illegal,
  output logic [15:0]         issue_cnt
);
  localparam int NREG = 2 ** AW;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

  // Sign-extend the immediate to the operand width.
  function automatic logic [DW-1:0] sext(input logic [IMMW-1:0] imm);
    return {{(DW-IMMW){imm[IMMW-1]}}, imm};
  endfunction

  // Ops the ALU understands; anything else is consumed and flagged.
  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [DW-1:0]   regs_r [NREG];
  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pending_next_s;

  logic            alu_valid_r;
  logic [DW-1:0]   alu_a_r;
  logic [DW-1:0]   alu_b_r;
  logic [2:0]      alu_op_r;
  logic [AW-1:0]   alu_rd_r;
  logic            err_illegal_r;
  logic [15:0]     issue_cnt_r;

  logic            rs_wb_hit_s;
  logic            rt_wb_hit_s;
  logic [DW-1:0]   rs_val_s;
  logic [DW-1:0]   rt_val_s;
  logic [DW-1:0]   b_val_s;
  logic            hazard_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            issue_s;
  logic            illegal_s;

  // Write-back address match on each source (register 0 never bypasses).
  always_comb begin
    rs_wb_hit_s = bus.wb_en && (bus.wb_addr == bus.in_rs);
    rt_wb_hit_s = bus.wb_en && (bus.wb_addr == bus.in_rt);
  end

  // Operand read with same-cycle write-back forwarding.
  always_comb begin
    rs_val_s = regs_r[bus.in_rs];
    rt_val_s = regs_r[bus.in_rt];
    if (rs_wb_hit_s && (bus.in_rs != REG_ZERO)) begin
      rs_val_s = bus.wb_data;
    end else begin
      rs_val_s = regs_r[bus.in_rs];
    end
    if (rt_wb_hit_s && (bus.in_rt != REG_ZERO)) begin
      rt_val_s = bus.wb_data;
    end else begin
      rt_val_s = regs_r[bus.in_rt];
    end
    if (bus.in_use_imm) begin
      b_val_s = sext(bus.in_imm);
    end else begin
      b_val_s = rt_val_s;
    end
  end

  // Hazard detection and handshake: a write-back arriving this cycle resolves the stall.
  always_comb begin
    hazard_s   = (pending_r[bus.in_rs] && !rs_wb_hit_s) ||
                 (!bus.in_use_imm && pending_r[bus.in_rt] && !rt_wb_hit_s);
    in_ready_s = (!alu_valid_r || bus.alu_ready) && !hazard_s;
    accept_s   = bus.in_valid && in_ready_s;
    issue_s    = accept_s && op_legal(bus.in_op);
    illegal_s  = accept_s && !op_legal(bus.in_op);
  end

  // Next scoreboard: write-back clears, issue sets, and set wins on the same register.
  always_comb begin
    pending_next_s = pending_r;
    if (bus.wb_en) begin
      pending_next_s[bus.wb_addr] = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
    if (issue_s && (bus.in_rd != REG_ZERO)) begin
      pending_next_s[bus.in_rd] = 1'b1;
    end else begin
      pending_next_s[0] = 1'b0;
    end
  end

  // Register file write; register 0 stays hard-wired to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (bus.wb_en && (bus.wb_addr != REG_ZERO)) begin
      regs_r[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Pending scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Output slot toward the ALU: load on issue, drain when consumed, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_r <= 1'b0;
      alu_a_r     <= {DW{1'b0}};
      alu_b_r     <= {DW{1'b0}};
      alu_op_r    <= 3'd0;
      alu_rd_r    <= {AW{1'b0}};
    end else if (issue_s) begin
      alu_valid_r <= 1'b1;
      alu_a_r     <= rs_val_s;
      alu_b_r     <= b_val_s;
      alu_op_r    <= bus.in_op;
      alu_rd_r    <= bus.in_rd;
    end else if (bus.alu_ready) begin
      alu_valid_r <= 1'b0;
    end
  end

  // Sticky illegal-op flag and wrapping issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal_r <= 1'b0;
      issue_cnt_r   <= 16'd0;
    end else begin
      if (illegal_s) begin
        err_illegal_r <= 1'b1;
      end
      if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.alu_valid = alu_valid_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.alu_rd    = alu_rd_r;
  assign err_illegal   = err_illegal_r;
  assign issue_cnt     = issue_cnt_r;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized traffic,
// all checked against a register-file/scoreboard reference model kept here.
module tb_alu_operand_stage;
  logic        clk;
  logic        rst_n;
  logic        err_illegal;
  logic [15:0] issue_cnt;

  alu_operand_stage_if #(.DW(32), .AW(5), .IMMW(16)) bus ();

  alu_operand_stage #(.DW(32), .AW(5), .IMMW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_illegal (err_illegal),
    .issue_cnt   (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_reg  [32];
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  bit          m_err;
  logic [15:0] m_cnt;

  logic [2:0]  legal_ops [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_op = 3'd0; m_rd = 5'd0;
    m_err = 1'b0; m_cnt = 16'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == addr) return bus.wb_data;
    return m_reg[addr];
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = (m_pend[bus.in_rs] && !(bus.wb_en && bus.wb_addr == bus.in_rs)) ||
         (!bus.in_use_imm && m_pend[bus.in_rt] && !(bus.wb_en && bus.wb_addr == bus.in_rt));
    return (!m_valid || bus.alu_ready) && !hz;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic m_edge();
    bit acc, legal;
    logic [31:0] ra, rb;
    acc   = bus.in_valid && m_ready();
    legal = bus.in_op inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
    ra    = m_read(bus.in_rs);
    rb    = bus.in_use_imm ? 32'($signed(bus.in_imm)) : m_read(bus.in_rt);
    if (acc && legal) begin
      m_valid = 1'b1; m_a = ra; m_b = rb; m_op = bus.in_op; m_rd = bus.in_rd;
      m_cnt   = m_cnt + 16'd1;
    end else if (bus.alu_ready) begin
      m_valid = 1'b0;
    end
    if (acc && !legal) m_err = 1'b1;
    if (bus.wb_en && bus.wb_addr != 5'd0) begin
      m_reg[bus.wb_addr]  = bus.wb_data;
      m_pend[bus.wb_addr] = 1'b0;
    end
    if (acc && legal && bus.in_rd != 5'd0) m_pend[bus.in_rd] = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".alu_valid"}, 32'(bus.alu_valid), 32'(m_valid));
    check({tag, ".alu_a"},     bus.alu_a,          m_a);
    check({tag, ".alu_b"},     bus.alu_b,          m_b);
    check({tag, ".alu_op"},    32'(bus.alu_op),    32'(m_op));
    check({tag, ".alu_rd"},    32'(bus.alu_rd),    32'(m_rd));
    check({tag, ".err"},       32'(err_illegal),   32'(m_err));
    check({tag, ".cnt"},       32'(issue_cnt),     32'(m_cnt));
  endtask

  // Called at a negedge with inputs already driven: check ready, clock, check outputs.
  task automatic step(input string tag);
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_ready()));
    @(posedge clk);
    m_edge();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_op = 3'd2; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
    bus.in_rd = 5'd0; bus.in_imm = 16'd0; bus.in_use_imm = 1'b0;
    bus.alu_ready = 1'b1; bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit use_imm, input logic [15:0] imm);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_rd = rd; bus.in_use_imm = use_imm; bus.in_imm = imm;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear immediately.
  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] hold_a, hold_b;
  logic [15:0] cnt_before;
  int          start;

  initial begin
    legal_ops[0] = 3'd0; legal_ops[1] = 3'd1; legal_ops[2] = 3'd2;
    legal_ops[3] = 3'd6; legal_ops[4] = 3'd7;
    idle();
    m_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: write r1, r2 and add them
    idle(); wb(5'd1, 32'd5); step("t1.wb1");
    idle(); wb(5'd2, 32'hFFFF_FFFD); step("t1.wb2");
    idle(); issue(3'd2, 5'd1, 5'd2, 5'd3, 1'b0, 16'd0); step("t1.add");
    check("t1.a", bus.alu_a, 32'd5);
    check("t1.b", bus.alu_b, 32'hFFFF_FFFD);
    check("t1.op", 32'(bus.alu_op), 32'd2);
    check("t1.rd", 32'(bus.alu_rd), 32'd3);
    check("t1.cnt", 32'(issue_cnt), 32'd1);

    // 2: RAW hazard on r4 resolved by a write-back with bypass
    idle(); issue(3'd2, 5'd5, 5'd6, 5'd4, 1'b0, 16'd0); step("t2.add");
    idle(); issue(3'd6, 5'd4, 5'd1, 5'd8, 1'b0, 16'd0);
    #1 check("t2.stall0", 32'(bus.in_ready), 32'd0);
    step("t2.stall1");
    step("t2.stall2");
    wb(5'd4, 32'd9); step("t2.wbacc");
    check("t2.bypass_a", bus.alu_a, 32'd9);
    check("t2.sub_op", 32'(bus.alu_op), 32'd6);

    // 3: immediate with sign extension; pending rt must not stall
    idle(); issue(3'd2, 5'd0, 5'd3, 5'd9, 1'b1, 16'h8000);
    #1 check("t3.ready", 32'(bus.in_ready), 32'd1);
    step("t3.imm");
    check("t3.a", bus.alu_a, 32'd0);
    check("t3.b", bus.alu_b, 32'hFFFF_8000);

    // 4: downstream backpressure holds the slot
    hold_a = m_a; hold_b = m_b;
    idle(); bus.alu_ready = 1'b0; issue(3'd1, 5'd0, 5'd0, 5'd0, 1'b1, 16'd1);
    for (int i = 0; i < 3; i++) begin
      #1 check("t4.ready", 32'(bus.in_ready), 32'd0);
      step("t4.hold");
      check("t4.a_stable", bus.alu_a, hold_a);
      check("t4.b_stable", bus.alu_b, hold_b);
    end
    bus.alu_ready = 1'b1; step("t4.release");
    check("t4.next_b", bus.alu_b, 32'd1);
    check("t4.next_op", 32'(bus.alu_op), 32'd1);

    // 5: illegal op, then reset in the middle of a stall
    cnt_before = m_cnt;
    idle(); issue(3'd3, 5'd0, 5'd0, 5'd10, 1'b1, 16'd0); step("t5.illegal");
    check("t5.err", 32'(err_illegal), 32'd1);
    check("t5.valid", 32'(bus.alu_valid), 32'd0);
    check("t5.cnt", 32'(issue_cnt), 32'(cnt_before));
    idle(); issue(3'd2, 5'd0, 5'd0, 5'd7, 1'b1, 16'd3); step("t5.rd7");
    idle(); bus.alu_ready = 1'b0; issue(3'd2, 5'd7, 5'd0, 5'd11, 1'b1, 16'd0); step("t5.stall");
    reset_pulse("t5.rst");
    idle(); issue(3'd2, 5'd7, 5'd0, 5'd11, 1'b1, 16'd0);
    #1 check("t5.pend_cleared", 32'(bus.in_ready), 32'd1);
    step("t5.after");
    check("t5.a_zero", bus.alu_a, 32'd0);

    // 6: register 0 ignores writes and bypass
    idle(); wb(5'd0, 32'h1234); step("t6.wb0");
    idle(); wb(5'd0, 32'h5678); issue(3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0); step("t6.rd0");
    check("t6.a", bus.alu_a, 32'd0);
    check("t6.b", bus.alu_b, 32'd0);

    // Randomized traffic with write-backs steered toward pending registers
    for (int c = 0; c < 3000; c++) begin
      idle();
      bus.alu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        bus.in_valid   = 1'b1;
        bus.in_op      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 5))
                                                     : legal_ops[$urandom_range(0, 4)];
        bus.in_rs      = 5'($urandom);
        bus.in_rt      = 5'($urandom);
        bus.in_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        bus.in_imm     = 16'($urandom);
        bus.in_use_imm = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.wb_en   = 1'b1;
        bus.wb_data = $urandom;
        bus.wb_addr = 5'($urandom);
        start = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          if (m_pend[(start + k) % 32]) begin
            bus.wb_addr = 5'((start + k) % 32);
            break;
          end
        end
      end
      step("rand");
    end

    // Counter wrap after 65536 issues from reset
    idle();
    reset_pulse("wrap.rst");
    issue(3'd2, 5'd0, 5'd0, 5'd0, 1'b1, 16'd1);
    for (int i = 0; i < 65536; i++) begin
      #1;
      if (i == 65535) check("wrap.ffff", 32'(issue_cnt), 32'hFFFF);
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end
    check_outputs("wrap");
    check("wrap.zero", 32'(issue_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
